// File: rtl/xors_tap_combiner.sv
// Feedback-tap combiner: picks NUM_OF_TAPS bits of a state register by packed 8-bit indices
// and registers their XOR parity. Optional build macro: XORS_TAP_SKIP_EN (index MSB disables a tap).
module xors_tap_combiner #(
    parameter int NUM_OF_TAPS = 15,
    parameter int REG_WIDTH   = 16,
    parameter int TAP_WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             res,
    input  logic [NUM_OF_TAPS*TAP_WIDTH-1:0] co_buf,
    input  logic [REG_WIDTH-1:0]             register,
    output logic                             result
);

    logic [NUM_OF_TAPS-1:0] tap_bit;
    logic                   parity;

    for (genvar i = 0; i < NUM_OF_TAPS; i++) begin : g_tap
        logic [TAP_WIDTH-1:0] idx;
        logic                 sel_bit;
        logic                 tap_en;

        assign idx = co_buf[i*TAP_WIDTH +: TAP_WIDTH];

        // One-hot decode of the index: an index >= REG_WIDTH matches no position and yields 0.
        always_comb begin
            sel_bit = 1'b0;
            for (int j = 0; j < REG_WIDTH; j++) begin
                if (32'(idx) == $unsigned(j)) begin
                    sel_bit = register[j];
                end
            end
        end

`ifdef XORS_TAP_SKIP_EN
        assign tap_en = ~idx[TAP_WIDTH-1];
`else
        assign tap_en = 1'b1;
`endif

        assign tap_bit[i] = sel_bit & tap_en;
    end

    // Reduction XOR; duplicate taps cancel pairwise as a natural consequence.
    assign parity = ^tap_bit;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            result <= 1'b0;
        end else begin
            result <= parity;
        end
    end

endmodule

// File: tb/tb_xors_tap_combiner.sv
// Directed self-checking bench for xors_tap_combiner: default 15-tap instance plus a
// single-tap instance for the degenerate mux case.
module tb_xors_tap_combiner;

    localparam int NT = 15;
    localparam int RW = 16;
    localparam int TW = 8;

    logic              clk;
    logic              res;
    logic [NT*TW-1:0]  co_buf;
    logic [RW-1:0]     register;
    logic              result;

    logic [TW-1:0]     co_buf1;
    logic [RW-1:0]     register1;
    logic              result1;

    int checks;
    int errors;

    logic [NT*TW-1:0] common_buf;
    logic [NT*TW-1:0] oor_buf;
    logic [NT*TW-1:0] skip_buf;

    xors_tap_combiner #(.NUM_OF_TAPS(NT), .REG_WIDTH(RW), .TAP_WIDTH(TW)) dut (
        .clk      (clk),
        .res      (res),
        .co_buf   (co_buf),
        .register (register),
        .result   (result)
    );

    xors_tap_combiner #(.NUM_OF_TAPS(1), .REG_WIDTH(RW), .TAP_WIDTH(TW)) dut1 (
        .clk      (clk),
        .res      (res),
        .co_buf   (co_buf1),
        .register (register1),
        .result   (result1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic drive(input logic [NT*TW-1:0] cb, input logic [RW-1:0] rg);
        @(negedge clk);
        co_buf   = cb;
        register = rg;
    endtask

    task automatic step_check(input string tag, input logic exp);
        @(posedge clk);
        #1;
        check_bit(tag, result, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        common_buf = 120'h01060e050f00010b0b080f060a0108;
        oor_buf    = {{(NT-1){8'h20}}, 8'h03};
        skip_buf   = {{(NT-1){8'h20}}, 8'h83};

        res       = 1'b1;
        co_buf    = common_buf;
        register  = 16'h0001;
        co_buf1   = 8'h05;
        register1 = 16'h0020;
        #12;
        check_bit("reset_initial", result, 1'b0);
        check_bit("reset_initial_1tap", result1, 1'b0);

        // release reset, first edge registers parity of bit 0
        @(negedge clk);
        res = 1'b0;
        step_check("bit0_set", 1'b1);
        #0 check_bit("one_tap_bit5", result1, 1'b1);

        drive(common_buf, 16'h0003);
        register1 = 16'h0000;
        step_check("bits0_1_cancel", 1'b0);
        check_bit("one_tap_zero", result1, 1'b0);

        // get a 1 back, then assert reset between edges
        drive(common_buf, 16'hFFFF);
        step_check("all_ones", 1'b1);
        #2;
        res = 1'b1;
        #1;
        check_bit("async_reset_immediate", result, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_bit("reset_held", result, 1'b0);
        end
        @(negedge clk);
        res = 1'b0;
        step_check("after_release_ffff", 1'b1);

        drive(common_buf, 16'h0100);
        step_check("dup_bit8", 1'b0);
        drive(common_buf, 16'h8000);
        step_check("dup_bit15", 1'b0);
        drive(common_buf, 16'h4421);
        step_check("four_taps_even", 1'b0);
        drive(common_buf, 16'h0400);
        step_check("bit10_single", 1'b1);
        drive(common_buf, 16'h0002);
        step_check("bit1_triple", 1'b1);
        drive(common_buf, 16'h0040);
        step_check("bit6_dup", 1'b0);

        drive(oor_buf, 16'h0008);
        step_check("oor_tap0_bit3", 1'b1);
        drive(oor_buf, 16'h0000);
        step_check("oor_zero", 1'b0);
        drive(oor_buf, 16'hFFF7);
        step_check("oor_others_ignored", 1'b0);

        // 0x83 is out of range without the macro and disabled with it
        drive(skip_buf, 16'h0008);
        step_check("skip_0x83", 1'b0);

        @(negedge clk);
        co_buf1   = 8'h10;
        register1 = 16'hFFFF;
        @(posedge clk);
        #1;
        check_bit("one_tap_oor", result1, 1'b0);
        @(negedge clk);
        co_buf1 = 8'h0F;
        @(posedge clk);
        #1;
        check_bit("one_tap_bit15", result1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xors_tap_combiner.md
Name: xors_tap_combiner

Overview:
- Feedback-tap combiner for the random-number module's shift register.
- Each cycle it selects NUM_OF_TAPS bits of a state register using 8-bit tap indices packed in a coefficient buffer.
- It XORs the selected bits together and presents the parity as a registered one-bit feedback result.
- Sits between the state register and the LFSR/NLFSR feedback input.

Parameters:
- NUM_OF_TAPS, 15, number of tap indices packed in co_buf.
- REG_WIDTH, 16, width of the state register being tapped.
- TAP_WIDTH, 8, bits per tap index in co_buf.

Ports:
- clk  input  1  system clock, rising-edge active.
- res  input  1  asynchronous active-high reset.
- co_buf  input  NUM_OF_TAPS*TAP_WIDTH  packed tap indices; tap i = co_buf[i*TAP_WIDTH +: TAP_WIDTH], tap 0 in the LSBs.
- register  input  REG_WIDTH  state register to be tapped.
- result  output  1  registered XOR of all selected register bits.

Behaviour:
- Interface: one clock (clk); reset res is asynchronous and active-high.
- Reset: while res=1, result=0 immediately, independent of clk. The first update occurs on the first rising clk edge after res deasserts.
- Tap combine (combinational):
  - For each tap i: bit_i = register[idx_i] if idx_i < REG_WIDTH, else 0.
  - Out-of-range indices contribute nothing.
  - parity = XOR over i=0..NUM_OF_TAPS-1 of bit_i.
- Duplicate indices are legal and cancel pairwise: an index appearing an even number of times contributes 0.
- Latency: result <= parity on every rising clk edge while res=0, so result reflects the co_buf/register values sampled at the previous edge.
- No enable or handshake; result updates every cycle.
- Inputs are not registered internally. co_buf and register may change on any cycle; only values present at the sampling edge matter.
- Reset asserted mid-operation: result goes to 0 immediately and stays 0 until the first edge after release.
- NUM_OF_TAPS=1 degenerates to a registered single-bit mux.
- The structure must be a balanced or linear XOR reduction. No width overflow is possible since the output is 1 bit.

Optional Feature:
- Macro: XORS_TAP_SKIP_EN.
- With the macro defined:
  - A tap whose index MSB (bit TAP_WIDTH-1) is 1 is disabled and contributes 0, even if the lower bits would select a valid bit.
  - This allows co_buf slots to be left unused without relying on out-of-range indices.
- Without the macro: the full TAP_WIDTH index is compared against REG_WIDTH as described above. Indices of 128 and above are out of range for REG_WIDTH=16 and contribute 0 anyway; results differ only when REG_WIDTH > 128.

Test Plan:
- Common setup: co_buf=120'h01060e050f00010b0b080f060a0108. This gives tap indices 8,1,10,6,15,8,11,11,1,0,15,5,14,6,1, so the effective taps are bits 0,1,5,10,14.
- Reset: assert res=1 asynchronously between clock edges -> result=0 immediately; hold res=1 for 2 cycles -> result stays 0 regardless of inputs.
- Common setup, register=16'h0001, release reset -> result=1 after first rising edge; register=16'h0003 next cycle -> result=0 one cycle later.
- Common setup, register=16'h0100 (bit 8, duplicated tap) -> result=0; register=16'h8000 (bit 15, duplicated) -> result=0.
- Common setup, register=16'hFFFF -> result=1 (five effective taps); register=16'h4421 (bits 0,5,10,14) -> result=0.
- Out-of-range: all tap bytes 0x20 except tap 0=0x03, register=16'h0008 -> result=1; register=16'h0000 -> result=0.
- XORS_TAP_SKIP_EN defined: tap 0=0x83, others 0x20, register=16'h0008 -> result=0. Without the macro, the same stimulus -> result=0 (0x83 is out of range for REG_WIDTH=16).
